// File: rtl/map_tile_scanner.sv
// map_tile_scanner: reloads the 4x4 tile map into a back buffer on frame_start, swaps it whole into the front buffer,
// and answers pixel-to-tile-code lookups with a fixed 2-cycle latency.
module map_tile_scanner #(
    parameter int READ_LATENCY = 1,
    parameter int TILE_W       = 200,
    parameter int TILE_H       = 120
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_start,
    output logic [3:0] mem_address,
    output logic       mem_chipselect,
    output logic       mem_clken,
    input  logic [7:0] mem_readdata,
    input  logic       pix_valid,
    input  logic [9:0] pix_x,
    input  logic [8:0] pix_y,
    output logic       tile_valid,
    output logic [7:0] tile_code,
    output logic       tile_oob,
    output logic       map_ready,
    output logic       load_busy,
    output logic       load_overrun
);
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, SWAP} state_t;

    localparam logic [11:0] X1 = 12'(TILE_W);
    localparam logic [11:0] X2 = 12'(2 * TILE_W);
    localparam logic [11:0] X3 = 12'(3 * TILE_W);
    localparam logic [11:0] X4 = 12'(4 * TILE_W);
    localparam logic [11:0] Y1 = 12'(TILE_H);
    localparam logic [11:0] Y2 = 12'(2 * TILE_H);
    localparam logic [11:0] Y3 = 12'(3 * TILE_H);
    localparam logic [11:0] Y4 = 12'(4 * TILE_H);

    state_t                  state, state_nx;
    logic [3:0]              cnt;
    logic [READ_LATENCY-1:0] cap_v;
    logic [3:0]              cap_a [READ_LATENCY];
    logic [7:0]              back  [16];
    logic [7:0]              front [16];
    logic [11:0]             x, y;
    logic [1:0]              col_c, row_c, s1_col, s1_row;
    logic                    oob_c, s1_oob, s1_v;

    assign mem_address = cnt;

    always_comb begin
        state_nx       = state;
        mem_chipselect = (state == LOAD);
        load_busy      = (state != IDLE);
        case (state)
            IDLE:    if (frame_start) state_nx = LOAD;
            LOAD:    if (cnt == 4'd15) state_nx = DRAIN;
            // leave DRAIN in the cycle the address-15 word is being captured
            DRAIN:   if (cap_v[READ_LATENCY-1] && cap_a[READ_LATENCY-1] == 4'd15) state_nx = SWAP;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        x     = 12'(pix_x);
        y     = 12'(pix_y);
        col_c = (x >= X3) ? 2'd3 : (x >= X2) ? 2'd2 : (x >= X1) ? 2'd1 : 2'd0;
        row_c = (y >= Y3) ? 2'd3 : (y >= Y2) ? 2'd2 : (y >= Y1) ? 2'd1 : 2'd0;
        oob_c = (x >= X4) || (y >= Y4);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            cap_v        <= '0;
            mem_clken    <= 1'b0;
            map_ready    <= 1'b0;
            load_overrun <= 1'b0;
            s1_v         <= 1'b0;
            s1_oob       <= 1'b0;
            s1_col       <= '0;
            s1_row       <= '0;
            tile_valid   <= 1'b0;
            tile_oob     <= 1'b0;
            tile_code    <= '0;
            for (int i = 0; i < READ_LATENCY; i++) cap_a[i] <= '0;
            for (int i = 0; i < 16; i++) begin
                back[i]  <= '0;
                front[i] <= '0;
            end
        end else begin
            state     <= state_nx;
            mem_clken <= 1'b1;
            if (state == IDLE && frame_start) cnt <= '0;
            else if (state == LOAD && cnt != 4'd15) cnt <= cnt + 4'd1;
            cap_v[0] <= mem_chipselect;
            cap_a[0] <= mem_address;
            for (int i = 1; i < READ_LATENCY; i++) begin
                cap_v[i] <= cap_v[i-1];
                cap_a[i] <= cap_a[i-1];
            end
            if (cap_v[READ_LATENCY-1]) back[cap_a[READ_LATENCY-1]] <= mem_readdata;
            if (state == SWAP) begin
                for (int i = 0; i < 16; i++) front[i] <= back[i];
                map_ready <= 1'b1;
            end
            if (frame_start && load_busy) load_overrun <= 1'b1;
            s1_v       <= pix_valid;
            s1_col     <= col_c;
            s1_row     <= row_c;
            s1_oob     <= oob_c;
            tile_valid <= s1_v;
            tile_oob   <= s1_oob;
            // front is read before a coincident SWAP updates it
            tile_code  <= s1_oob ? 8'h00 : front[{s1_row, s1_col}];
        end
    end
endmodule

// File: tb/tb_map_tile_scanner.sv
// tb_map_tile_scanner: runs scanners with read latency 1 and 3 side by side against a frame-level model
// (load timeline from frame_start, map snapshot at swap, tile lookup by division), plus literal expectations.
module tb_map_tile_scanner;
    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       frame_start = 1'b0;
    logic       pix_valid = 1'b0;
    logic [9:0] pix_x = '0;
    logic [8:0] pix_y = '0;
    logic [7:0] mem [16];

    logic [3:0] addr_o [2];
    logic       cs_o [2], clken_o [2], tv_o [2], oob_o [2], rdy_o [2], busy_o [2], ovr_o [2];
    logic [7:0] code_o [2], rdata [2];

    int checks = 0, failures = 0, n = 0;
    int lit_rdy = -1, lit_busy = -1, lit_ovr = -1, pix_lit = -1;

    int         fs_c [2];
    bit         ld [2], rdy [2], ovr [2], seen [2];
    logic [7:0] fr [2][16];
    bit         s1v, s2v [2], s2o [2];
    int         s1x, s1y, s1l = -1, s2c [2], s2l = -1;
    int         rl, k;
    bit         busy_m, cs_m;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int RL = g ? 3 : 1;
        logic [7:0] q [RL];
        always @(posedge clk) begin
            q[0] <= mem[addr_o[g]];
            for (int j = 1; j < RL; j++) q[j] <= q[j-1];
        end
        assign rdata[g] = q[RL-1];
        map_tile_scanner #(.READ_LATENCY(RL)) dut (
            .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
            .mem_address(addr_o[g]), .mem_chipselect(cs_o[g]), .mem_clken(clken_o[g]),
            .mem_readdata(rdata[g]), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
            .tile_valid(tv_o[g]), .tile_code(code_o[g]), .tile_oob(oob_o[g]),
            .map_ready(rdy_o[g]), .load_busy(busy_o[g]), .load_overrun(ovr_o[g])
        );
    end

    task automatic chk(input string nm, input int i, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s inst%0d cycle %0d: got 0x%0h, expected 0x%0h", nm, i, n, act, exp);
        end
    endtask

    function automatic bit is_oob(input int x, input int y);
        return x >= 800 || y >= 480;
    endfunction

    function automatic int lookup(input int i, input int x, input int y);
        return is_oob(x, y) ? 0 : int'(fr[i][(y / 120) * 4 + x / 200]);
    endfunction

    always @(negedge clk) begin
        n++;
        for (int i = 0; i < 2; i++) begin
            rl = i ? 3 : 1;
            if (!reset_n) begin
                chk("reset_outputs", i, int'({addr_o[i], cs_o[i], clken_o[i], tv_o[i], code_o[i],
                    oob_o[i], rdy_o[i], busy_o[i], ovr_o[i]}), 0);
                ld[i] = 0; rdy[i] = 0; ovr[i] = 0; seen[i] = 0;
                s2v[i] = 0; s2o[i] = 0; s2c[i] = 0;
                for (int j = 0; j < 16; j++) fr[i][j] = '0;
                if (i == 0) s2l = -1;
            end else begin
                k = n - fs_c[i];
                busy_m = ld[i] && k >= 1 && k <= 17 + rl;
                cs_m = ld[i] && k >= 1 && k <= 16;
                chk("mem_chipselect", i, int'(cs_o[i]), int'(cs_m));
                if (cs_m) chk("mem_address", i, int'(addr_o[i]), k - 1);
                chk("load_busy", i, int'(busy_o[i]), int'(busy_m));
                chk("map_ready", i, int'(rdy_o[i]), int'(rdy[i]));
                chk("load_overrun", i, int'(ovr_o[i]), int'(ovr[i]));
                chk("mem_clken", i, int'(clken_o[i]), int'(seen[i]));
                chk("tile_valid", i, int'(tv_o[i]), int'(s2v[i]));
                chk("tile_oob", i, int'(oob_o[i]), int'(s2o[i]));
                chk("tile_code", i, int'(code_o[i]), s2c[i]);
                if (i == 0) begin
                    if (s2l >= 0) chk("tile_code_literal", i, int'(code_o[0]), s2l);
                    if (lit_rdy >= 0) chk("map_ready_literal", i, int'(rdy_o[0]), lit_rdy);
                    if (lit_busy >= 0) chk("load_busy_literal", i, int'(busy_o[0]), lit_busy);
                    if (lit_ovr >= 0) chk("load_overrun_literal", i, int'(ovr_o[0]), lit_ovr);
                    s2l = s1l;
                end
                s2v[i] = s1v;
                s2o[i] = is_oob(s1x, s1y);
                s2c[i] = lookup(i, s1x, s1y);
                seen[i] = 1;
                if (ld[i] && k == 17 + rl) begin
                    for (int j = 0; j < 16; j++) fr[i][j] = mem[j];
                    rdy[i] = 1;
                    ld[i] = 0;
                end
                if (frame_start) begin
                    if (busy_m) ovr[i] = 1;
                    else begin
                        ld[i] = 1;
                        fs_c[i] = n;
                    end
                end
            end
        end
        if (!reset_n) begin
            s1v = 0; s1x = 0; s1y = 0; s1l = -1;
        end else begin
            s1v = pix_valid; s1x = int'(pix_x); s1y = int'(pix_y);
            s1l = pix_valid ? pix_lit : -1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input int x, input int y, input int lit);
        pix_valid = 1'b1;
        pix_x = 10'(x);
        pix_y = 9'(y);
        pix_lit = lit;
        tick();
        pix_valid = 1'b0;
        pix_lit = -1;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        for (int j = 0; j < 16; j++) mem[j] = 8'(8'h10 + j);
        #1 reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (3) tick();

        // first load, latency-1 timeline pinned by literals
        pulse_frame();
        lit_busy = 1; lit_rdy = 0;
        tick();
        lit_busy = -1; lit_rdy = -1;
        repeat (15) tick();
        px(0, 0, 8'h00);
        lit_busy = 1; lit_rdy = 0;
        tick();
        lit_busy = 0; lit_rdy = 1;
        px(0, 0, 8'h10);
        lit_busy = -1; lit_rdy = -1;
        repeat (3) tick();

        px(0, 0, 8'h10);
        px(799, 479, 8'h1F);
        px(200, 120, 8'h15);
        px(199, 119, 8'h10);
        tick();
        px(800, 0, 8'h00);
        px(0, 480, 8'h00);
        px(400, 240, 8'h1A);
        px(799, 0, 8'h13);
        px(0, 479, 8'h1C);
        px(1023, 511, 8'h00);
        repeat (3) tick();

        // overrun during a load, then reload with new contents
        pulse_frame();
        repeat (4) tick();
        pulse_frame();
        lit_ovr = 1;
        tick();
        lit_ovr = -1;
        repeat (20) tick();
        for (int j = 0; j < 16; j++) mem[j] = 8'(8'hF0 - j);
        pulse_frame();
        for (int j = 0; j < 16; j++) px(j * 50, j * 30, -1);
        px(0, 0, 8'h10);
        px(200, 0, -1);
        px(0, 0, 8'hF0);
        px(799, 479, 8'hE1);
        repeat (3) tick();

        // reset in the middle of a load, then a fresh load
        pulse_frame();
        repeat (7) tick();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        px(0, 0, 8'h00);
        repeat (2) tick();
        for (int j = 0; j < 16; j++) mem[j] = 8'(8'h30 + j);
        pulse_frame();
        repeat (21) tick();
        px(799, 479, 8'h3F);
        px(0, 0, 8'h30);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
